// File: rtl/branch_target_predictor.sv
// Branch target buffer for the RV32I fetch stage.
// Direct-mapped table of {valid, tag, target, 2-bit counter}. The IF lookup is
// combinational from the registered table. EX-stage training and flush
// generation happen here too. Optional statistics counters are built when
// BRANCH_PREDICTOR_STATS_EN is defined; otherwise both count ports read 0.
module branch_target_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  input  logic        StallE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  // Encoding of "not a branch" in the pipeline's BranchTypeE field
  localparam logic [2:0] NOBRANCH = 3'd0;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Instructions are word aligned, so the low PC bits carry no information
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // ---------------- IF lookup ----------------
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f       = PCF[IDX_W+1:2];
  assign tag_f       = PCF[31:IDX_W+2];
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f & ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : 32'd0;

  // ---------------- EX resolution ----------------
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic             is_branch;
  logic             upd;
  logic             train;
  logic             alloc;
  logic             stale_clr;
  logic [1:0]       ctr_e;
  logic [1:0]       ctr_d;

  assign idx_e     = PCE[IDX_W+1:2];
  assign tag_e     = PCE[31:IDX_W+2];
  assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign is_branch = (BranchTypeE != NOBRANCH);
  assign upd       = is_branch & ~StallE & ~rst;
  assign train     = upd & hit_e;
  assign alloc     = upd & ~hit_e & BranchE;
  // A non-branch that was predicted taken means the entry is stale: drop it
  assign stale_clr = ~is_branch & ~StallE & ~rst & PredTakenE & hit_e;
  assign ctr_e     = ctr_q[idx_e];

  // Saturating counter step for the entry being trained
  always_comb begin
    ctr_d = ctr_e;
    if (BranchE) begin
      if (ctr_e != 2'b11) ctr_d = ctr_e + 2'b01;
    end else begin
      if (ctr_e != 2'b00) ctr_d = ctr_e - 2'b01;
    end
  end

  // Flush request and redirect PC; a held or resetting EX never flushes
  always_comb begin
    MispredictE = 1'b0;
    if (!StallE && !rst) begin
      if (is_branch)
        MispredictE = (BranchE != PredTakenE) |
                      (BranchE & PredTakenE & (PredTargetE != BranchTargetE));
      else
        MispredictE = PredTakenE;
    end
  end

  assign CorrectPCE = (is_branch & BranchE) ? BranchTargetE : (PCE + 32'd4);

  // Table state: reset clears valid and sets weak-NT, otherwise one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (train) begin
      ctr_q[idx_e] <= ctr_d;
      if (BranchE) target_q[idx_e] <= BranchTargetE;
    end else if (alloc) begin
      valid_q[idx_e]  <= 1'b1;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= BranchTargetE;
      ctr_q[idx_e]    <= 2'b10;
    end else if (stale_clr) begin
      valid_q[idx_e] <= 1'b0;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Free-running, wrapping statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (upd)         branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (MispredictE) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
`else
  assign BranchCount  = 32'd0;
  assign MispredCount = 32'd0;
`endif

endmodule
